// File: rtl/iram_port_arbiter_if.sv
// Bus bundle for the instruction-RAM port arbiter: CPU fetch side,
// debug/loader side and the single synchronous RAM port.
interface iram_port_arbiter_if #(
    parameter int RAM_AW = 12
);
    // CPU fetch requester
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    // Debug / program-loader requester
    logic              dbg_req;
    logic              dbg_we;
    logic [3:0]        dbg_be;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              dbg_err;

    // Instruction RAM port
    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output ram_addr, ram_we, ram_din,
        input  ram_dout
    );

    // Environment side: both requesters plus the RAM model
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  ram_addr, ram_we, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/iram_port_arbiter.sv
// Shares the single synchronous instruction-RAM port between the CPU fetch
// stage and the debug/program-loader port. Debug has priority, but after
// DBG_BURST_MAX consecutive debug grants with the CPU waiting, the CPU is
// forced through. Responses come back exactly one cycle after the grant.
module iram_port_arbiter #(
    parameter int ADDR_HI_BITS  = 18,
    parameter int RAM_AW        = 12,
    parameter int DBG_BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    iram_port_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(DBG_BURST_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // Grant and address decode
    logic              if_valid;
    logic              dbg_valid;
    logic              if_gnt;
    logic              dbg_gnt;
    logic              any_gnt;
    logic              gnt_valid;
    logic [31:0]       gnt_addr;

    // Burst counter
    logic [CNT_W-1:0]  burst_q;
    logic [CNT_W-1:0]  burst_d;
    logic              burst_full;

    // RAM drive
    logic [RAM_AW-1:0] ram_addr_q;
    logic [RAM_AW-1:0] ram_addr_d;
    logic [3:0]        ram_we_lane;

    // Response owner
    owner_e            owner_q;
    owner_e            owner_d;
    logic              valid_q;
    logic              valid_d;
    logic              wr_q;
    logic              wr_d;

    // Response outputs
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              dbg_err;

    // Low byte-offset bits never matter for a word-wide RAM
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr, bus.dbg_addr};

    // Only the bottom 16 kB is backed by RAM; anything with an upper bit set
    // is out of range.
    assign if_valid  = (bus.if_addr[31 -: ADDR_HI_BITS]  == '0);
    assign dbg_valid = (bus.dbg_addr[31 -: ADDR_HI_BITS] == '0);

    assign burst_full = (burst_q == CNT_W'(DBG_BURST_MAX));

    // Fixed-priority grant: debug first unless the CPU has waited out a full burst
    always_comb begin
        dbg_gnt = 1'b0;
        if_gnt  = 1'b0;
        if (!rst) begin
            if (bus.dbg_req && !(bus.if_req && burst_full)) begin
                dbg_gnt = 1'b1;
            end else if (bus.if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    assign any_gnt   = if_gnt | dbg_gnt;
    assign gnt_addr  = dbg_gnt ? bus.dbg_addr : bus.if_addr;
    assign gnt_valid = dbg_gnt ? dbg_valid    : if_valid;

    // Count debug grants that made the CPU wait; any CPU grant or idle CPU clears it
    always_comb begin
        burst_d = burst_q;
        if (if_gnt || !bus.if_req) begin
            burst_d = '0;
        end else if (dbg_gnt && !burst_full) begin
            burst_d = burst_q + 1'b1;
        end
    end

    // Burst counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    // RAM address follows the granted requester and holds when idle
    always_comb begin
        ram_addr_d = ram_addr_q;
        if (any_gnt) begin
            ram_addr_d = gnt_addr[RAM_AW+1:2];
        end
    end

    // Remember the last presented address so an idle cycle keeps it stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_q <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
        end
    end

    // Byte-lane write enables: only an in-range debug write touches the RAM
    for (genvar gi = 0; gi < 4; gi++) begin : g_we_lane
        assign ram_we_lane[gi] = dbg_gnt & bus.dbg_we & dbg_valid & bus.dbg_be[gi];
    end

    assign bus.ram_addr = ram_addr_d;
    assign bus.ram_we   = ram_we_lane;
    assign bus.ram_din  = bus.dbg_wdata;
    assign bus.if_gnt   = if_gnt;
    assign bus.dbg_gnt  = dbg_gnt;

    // Response-owner state register, loaded at every edge from this cycle's grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
        end
    end

    // Next owner: whoever was granted now gets the response slot next cycle
    always_comb begin
        owner_d = OWN_NONE;
        valid_d = 1'b0;
        wr_d    = 1'b0;
        if (dbg_gnt) begin
            owner_d = OWN_DBG;
            valid_d = dbg_valid;
            wr_d    = bus.dbg_we;
        end else if (if_gnt) begin
            owner_d = OWN_CPU;
            valid_d = if_valid;
        end
    end

    // Route the registered RAM output to the owner; zero everywhere else
    always_comb begin
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        dbg_err    = 1'b0;
        case (owner_q)
            OWN_CPU: begin
                if_rvalid = 1'b1;
                if (valid_q) begin
                    if_rdata = bus.ram_dout;
                end
            end
            OWN_DBG: begin
                dbg_rvalid = 1'b1;
                dbg_err    = !valid_q;
                if (valid_q && !wr_q) begin
                    dbg_rdata = bus.ram_dout;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.if_rvalid  = if_rvalid;
    assign bus.if_rdata   = if_rdata;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.dbg_rdata  = dbg_rdata;
    assign bus.dbg_err    = dbg_err;

endmodule

// File: doc/iram_port_arbiter.md
Name: iram_port_arbiter

Overview:
- Shares the single synchronous port of the 16 kB instruction RAM between two requesters: the CPU fetch stage and the debug/program-loader port.
- Only the debug port may write. The CPU never writes the instruction RAM.
- Sits between the pipeline IF stage, the debug module and the InstructionRam instance.
- Does address-range checking, fixed-priority arbitration with an anti-starvation counter, and 1-cycle response routing.

Parameters:
- ADDR_HI_BITS, 18, number of upper byte-address bits that must be zero for an address to be valid (valid range 0x0000_0000..0x0000_3fff).
- RAM_AW, 12, RAM word-address width; the RAM is addressed by addr[RAM_AW+1:2].
- DBG_BURST_MAX, 4, maximum consecutive debug grants while the CPU is waiting before the CPU is forced a grant.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  CPU fetch request; held until if_gnt
- if_addr  in  32  CPU fetch byte address
- if_gnt  out  1  CPU request accepted this cycle
- if_rvalid  out  1  CPU read data valid; one cycle after if_gnt
- if_rdata  out  32  CPU read data
- dbg_req  in  1  debug request; held until dbg_gnt
- dbg_we  in  1  1 = write, 0 = read
- dbg_be  in  4  byte enables for writes
- dbg_addr  in  32  debug byte address
- dbg_wdata  in  32  debug write data
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug response (read data or write ack); one cycle after dbg_gnt
- dbg_rdata  out  32  debug read data (0 for writes)
- dbg_err  out  1  qualifies dbg_rvalid: the access was out of range
- ram_addr  out  RAM_AW  RAM word address
- ram_we  out  4  RAM byte write enables
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data; registered, valid the cycle after the address is presented

Behaviour:
- Reset values, while rst is high:
  - if_gnt, dbg_gnt = 0.
  - if_rvalid, dbg_rvalid, dbg_err = 0.
  - if_rdata, dbg_rdata = 0.
  - ram_we = 0.
  - Burst counter = 0; response-owner register = NONE.
- Grant rules (combinational from the request inputs and the counter):
  - At most one grant per cycle.
  - Only dbg_req: debug is granted.
  - Only if_req: CPU is granted.
  - Both requesting: debug is granted unless the counter equals DBG_BURST_MAX, in which case the CPU is granted.
- Burst counter:
  - Increments on each debug grant made while if_req = 1.
  - Clears on any CPU grant, or on any cycle in which if_req = 0.
  - Saturates at DBG_BURST_MAX.
- Request hold: a requester must hold req, addr and data stable until its gnt. Inputs are sampled only in the grant cycle. Changing them before gnt is a protocol violation and its behaviour is undefined.
- Address validity: an address is valid when addr[31:32-ADDR_HI_BITS] == 0. The low two address bits are ignored.
- RAM drive in the grant cycle:
  - ram_addr = granted addr[RAM_AW+1:2].
  - ram_we = dbg_be only for a valid debug write; otherwise 0. Out-of-range writes never reach the RAM.
  - ram_din = dbg_wdata.
  - With no grant: ram_we = 0 and ram_addr holds its last value.
- Response-owner register, loaded at the grant edge: NONE / CPU / DBG, plus the valid bit and the write bit.
- Response cycle (the cycle after the grant):
  - CPU: if_rvalid = 1; if_rdata = ram_dout if valid, else 0.
  - Debug read: dbg_rvalid = 1; dbg_rdata = ram_dout if valid, else 0; dbg_err = !valid.
  - Debug write: dbg_rvalid = 1; dbg_rdata = 0; dbg_err = !valid.
  - rdata outputs are 0 in every cycle where their rvalid is 0.
- Throughput: back-to-back grants are allowed every cycle. A grant and the response to the previous grant may occur in the same cycle.
- Read latency: exactly 1 cycle from gnt to rvalid. Write ack latency is also 1 cycle.
- Reset mid-operation: a pending response is dropped and no rvalid is issued for it. After reset deasserts, the first grant behaves like a fresh grant.
- Read-after-write by debug to the same word on consecutive grants returns the new data (RAM write-first / next-cycle read).

Test Plan:
- Reset, then a CPU read of 0x0000_0010 with the RAM word preloaded to 0x00A0_0093 -> if_gnt in cycle 0; if_rvalid = 1 and if_rdata = 0x00A0_0093 in cycle 1; ram_we = 0 throughout.
- CPU read of 0x0000_4000 (out of range) -> if_gnt = 1; next cycle if_rvalid = 1 and if_rdata = 0.
- Debug write 0xDEAD_BEEF with be = 4'b0011 to 0x0000_0020 (old word 0x1234_5678), then a debug read of the same address -> ram_we = 4'b0011 in the grant cycle; dbg_rvalid with dbg_err = 0; read returns 0x1234_BEEF.
- Debug write to 0x0001_0000 -> ram_we stays 0; next cycle dbg_rvalid = 1 and dbg_err = 1; RAM contents unchanged.
- Both requesters held continuously for 12 cycles with DBG_BURST_MAX = 4 -> grant pattern D,D,D,D,C repeating; every grant is followed by exactly one rvalid to the matching port.
- Assert rst for one cycle immediately after an if_gnt -> no if_rvalid follows; all outputs are 0; normal grants resume the cycle after rst deasserts.
